// File: rtl/team_06_delay_line_controller.sv
// Delay-line sequencer: once per audio sample, reads the delayed sample from a circular SRAM buffer
// and writes the new sample back at the head. The buffer is zero-filled whenever an effect is entered.
module team_06_delay_line_controller #(
   parameter int ADDR_W       = 13,
   parameter int ECHO_DELAY   = 6000,
   parameter int REVERB_DELAY = 1500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        sel,
   input  logic              finished,
   input  logic [7:0]        save_audio,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_done,
   output logic              search,
   output logic              record,
   output logic [ADDR_W-1:0] offset,
   output logic [7:0]        mem_wdata,
   output logic [7:0]        past_output,
   output logic              past_valid,
   output logic              overrun
);

   localparam logic [2:0]        SEL_ECHO   = 3'b010;
   localparam logic [2:0]        SEL_REVERB = 3'b100;
   localparam logic [ADDR_W-1:0] ECHO_D     = ADDR_W'(ECHO_DELAY);
   localparam logic [ADDR_W-1:0] REVERB_D   = ADDR_W'(REVERB_DELAY);
   localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

   typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, CLEAR} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] wr_ptr, clr_ptr, rd_addr;
   logic [7:0]        past_reg, wdata_reg;
   logic [2:0]        prev_sel;
   logic              pending, clear_req, overrun_reg;

   logic active, sel_change, in_chain, clear_done;

   assign active     = (sel == SEL_ECHO) || (sel == SEL_REVERB);
   assign sel_change = (sel != prev_sel);
   assign in_chain   = (state == READ) || (state == CAPTURE) || (state == WRITE);
   assign clear_done = (state == CLEAR) && mem_done && (clr_ptr == LAST_ADDR);

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (clear_req)
               state_next = CLEAR;
            else if (active && (finished || pending))
               state_next = READ;
         end
         READ:    if (mem_done) state_next = CAPTURE;
         CAPTURE: state_next = WRITE;
         WRITE:   if (mem_done) state_next = IDLE;
         CLEAR:   if (clear_done) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The read address is latched on entry to READ so a sel change mid-request cannot move it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         clr_ptr     <= '0;
         rd_addr     <= '0;
         past_reg    <= '0;
         wdata_reg   <= '0;
         prev_sel    <= '0;
         pending     <= 1'b0;
         clear_req   <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         state    <= state_next;
         prev_sel <= sel;

         if (state == IDLE && state_next == READ)
            rd_addr <= wr_ptr - ((sel == SEL_REVERB) ? REVERB_D : ECHO_D);

         if (state == IDLE && state_next == CLEAR)
            clr_ptr <= '0;
         else if (state == CLEAR && mem_done)
            clr_ptr <= clr_ptr + ADDR_W'(1);

         if (state == READ && mem_done)
            past_reg <= mem_rdata;
         else if (state == CLEAR)
            past_reg <= '0;

         if (state == CAPTURE)
            wdata_reg <= save_audio;

         if (state == WRITE && mem_done)
            wr_ptr <= wr_ptr + ADDR_W'(1);
         else if (clear_done)
            wr_ptr <= '0;

         if (sel_change && active)
            clear_req <= 1'b1;
         else if (clear_done)
            clear_req <= 1'b0;

         if (!active || state == CLEAR)
            pending <= 1'b0;
         else if (finished && in_chain)
            pending <= 1'b1;
         else if (state == IDLE && state_next == READ)
            pending <= 1'b0;

         if (sel_change)
            overrun_reg <= 1'b0;
         else if (active && finished && in_chain && pending)
            overrun_reg <= 1'b1;
      end
   end

   always_comb begin
      search      = (state == READ);
      record      = (state == WRITE) || (state == CLEAR);
      past_valid  = (state == CAPTURE);
      overrun     = overrun_reg;
      past_output = (state == CLEAR) ? 8'h00 : past_reg;
      mem_wdata   = (state == CLEAR) ? 8'h00 : wdata_reg;
      case (state)
         READ:    offset = rd_addr;
         WRITE:   offset = wr_ptr;
         CLEAR:   offset = clr_ptr;
         default: offset = '0;
      endcase
   end

endmodule

// File: tb/tb_team_06_delay_line_controller.sv
// Scoreboard bench for the delay-line sequencer: stimulus pushes expected SRAM transactions and
// delayed samples into queues, while a memory model and a monitor pop and compare them.
module tb_team_06_delay_line_controller;

   localparam int AW = 4;
   localparam int DEPTH = 16;

   typedef struct {
      logic          wr;
      logic [AW-1:0] off;
      logic [7:0]    data;
   } txn_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    sel;
   logic          finished;
   logic [7:0]    save_audio;
   logic [7:0]    mem_rdata;
   logic          mem_done;
   logic          search;
   logic          record;
   logic [AW-1:0] offset;
   logic [7:0]    mem_wdata;
   logic [7:0]    past_output;
   logic          past_valid;
   logic          overrun;

   int         n_checks = 0;
   int         n_pass = 0;
   int         req_cnt = 0;
   logic [7:0] sram [DEPTH];
   logic [7:0] exp_mem [DEPTH];
   int         exp_wr = 0;
   txn_t       exp_q [$];
   logic [7:0] past_q [$];

   always #5 clk = ~clk;

   team_06_delay_line_controller #(
      .ADDR_W(AW), .ECHO_DELAY(3), .REVERB_DELAY(5)
   ) dut (
      .clk(clk), .rst(rst), .sel(sel), .finished(finished), .save_audio(save_audio),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .search(search), .record(record),
      .offset(offset), .mem_wdata(mem_wdata), .past_output(past_output),
      .past_valid(past_valid), .overrun(overrun)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req)
         n_pass++;
      else
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   // Memory model: acknowledges each request on its second cycle and checks it against the scoreboard.
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         mem_done = 1'b0;
         req_cnt  = 0;
      end else if (mem_done) begin
         mem_done = 1'b0;
         req_cnt  = (search || record) ? 1 : 0;
      end else if (search || record) begin
         req_cnt++;
         if (req_cnt >= 2) begin
            checkOutput("req_exclusive", {31'd0, search & record}, 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("[TB] FAIL unexpected_txn: got record=%0b offset=%0d, expected none", record, offset);
            end else begin
               txn_t e;
               e = exp_q.pop_front();
               checkOutput("txn_kind", {31'd0, record}, {31'd0, e.wr});
               checkOutput("txn_offset", {28'd0, offset}, {28'd0, e.off});
               if (record)
                  checkOutput("txn_wdata", {24'd0, mem_wdata}, {24'd0, e.data});
            end
            if (record)
               sram[offset] = mem_wdata;
            else
               mem_rdata = sram[offset];
            mem_done = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst === 1'b1 && past_valid === 1'b1) begin
         if (past_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_past_valid: got %0h, expected none", past_output);
         end else begin
            logic [7:0] p;
            p = past_q.pop_front();
            checkOutput("past_output", {24'd0, past_output}, {24'd0, p});
         end
      end
   end

   task automatic expectClear();
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back('{1'b1, AW'(i), 8'h00});
         exp_mem[i] = 8'h00;
      end
      exp_wr = 0;
   endtask

   task automatic expectSample(input logic [7:0] d, input int delay, input bit with_write);
      logic [AW-1:0] rd;
      rd = AW'(exp_wr - delay + DEPTH);
      exp_q.push_back('{1'b0, rd, 8'h00});
      past_q.push_back(exp_mem[rd]);
      if (with_write) begin
         exp_q.push_back('{1'b1, AW'(exp_wr), d});
         exp_mem[exp_wr] = d;
         exp_wr = (exp_wr + 1) % DEPTH;
      end
   endtask

   task automatic waitDrain(input string name);
      int cyc = 0;
      while ((exp_q.size() != 0 || past_q.size() != 0) && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      if (exp_q.size() != 0 || past_q.size() != 0) begin
         n_checks++;
         $display("[TB] FAIL %s_timeout: got %0d txns outstanding, expected 0", name, exp_q.size());
      end
   endtask

   task automatic waitRecord(input string name);
      int cyc = 0;
      while (record !== 1'b1 && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      if (record !== 1'b1) begin
         n_checks++;
         $display("[TB] FAIL %s_timeout: got record=%0b, expected 1", name, record);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] d, input bit chk_latency);
      @(negedge clk);
      finished   = 1'b1;
      save_audio = d;
      @(negedge clk);
      finished = 1'b0;
      if (chk_latency)
         checkOutput("strobe_to_search", {31'd0, search}, 32'd1);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_search"}, {31'd0, search}, 32'd0);
      checkOutput({tag, "_record"}, {31'd0, record}, 32'd0);
      checkOutput({tag, "_offset"}, {28'd0, offset}, 32'd0);
      checkOutput({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
      checkOutput({tag, "_past"}, {24'd0, past_output}, 32'd0);
      checkOutput({tag, "_past_valid"}, {31'd0, past_valid}, 32'd0);
      checkOutput({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
   endtask

   initial begin
      rst        = 1'b0;
      sel        = 3'b010;
      finished   = 1'b0;
      save_audio = 8'h00;
      mem_rdata  = 8'h00;
      mem_done   = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         sram[i]    = 8'hEE;
         exp_mem[i] = 8'hEE;
      end

      repeat (3) @(negedge clk);
      checkReset("reset");

      // Leaving reset with echo selected zero-fills the whole buffer.
      expectClear();
      rst = 1'b1;
      waitDrain("initial_clear");
      checkOutput("overrun_after_clear", {31'd0, overrun}, 32'd0);

      for (int n = 0; n < 6; n++) begin
         expectSample(8'(8'h10 + n), 3, 1'b1);
         applyStimulus(8'(8'h10 + n), n == 0);
         waitDrain("echo_sample");
      end

      for (int n = 0; n < 17; n++) begin
         expectSample(8'(8'h40 + n), 3, 1'b1);
         applyStimulus(8'(8'h40 + n), 1'b0);
         waitDrain("wrap_sample");
      end

      // Strobe B lands in A's WRITE (pending), strobe C in the next cycle (overrun).
      expectSample(8'hA0, 3, 1'b1);
      expectSample(8'hB0, 3, 1'b1);
      applyStimulus(8'hA0, 1'b0);
      waitRecord("write_a");
      finished   = 1'b1;
      save_audio = 8'hB0;
      @(negedge clk);
      @(negedge clk);
      finished = 1'b0;
      checkOutput("idle_gap_search", {31'd0, search}, 32'd0);
      @(negedge clk);
      checkOutput("pending_service", {31'd0, search}, 32'd1);
      checkOutput("overrun_set", {31'd0, overrun}, 32'd1);
      waitDrain("pending_chain");
      checkOutput("overrun_sticky", {31'd0, overrun}, 32'd1);

      sel = 3'b000;
      repeat (2) @(negedge clk);
      checkOutput("overrun_cleared", {31'd0, overrun}, 32'd0);
      applyStimulus(8'h77, 1'b0);
      repeat (4) @(negedge clk);
      checkOutput("inactive_ignore", {31'd0, search}, 32'd0);

      expectClear();
      sel = 3'b010;
      waitDrain("reenter_clear");

      // Switching to reverb mid-READ lets the chain finish before the clear runs.
      expectSample(8'h55, 3, 1'b1);
      expectClear();
      @(negedge clk);
      finished   = 1'b1;
      save_audio = 8'h55;
      @(negedge clk);
      finished = 1'b0;
      sel      = 3'b100;
      waitDrain("switch_clear");
      expectSample(8'h66, 5, 1'b1);
      applyStimulus(8'h66, 1'b1);
      waitDrain("reverb_sample");

      expectSample(8'h99, 5, 1'b0);
      applyStimulus(8'h99, 1'b0);
      waitRecord("write_reset");
      rst = 1'b0;
      #1;
      checkReset("async_reset");
      sel = 3'b010;
      repeat (2) @(negedge clk);
      expectClear();
      rst = 1'b1;
      waitDrain("restart_clear");
      repeat (10) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
